// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART transmitter and receiver.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
    localparam int UART_DATA_BITS = 8;
    localparam int DEFAULT_BAUD_DIV = 868;
endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: synchronous FIFO with a registered occupancy count and a head word visible without a read latency.
module uart_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= din;
    assign dout  = mem[rd_ptr];
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered 8N1 transmitter; frames are sent back to back,
// the next start bit replacing the last stop-bit clock edge when a byte is waiting.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        uart_tx,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        fifo_empty
);
    localparam int BW = $clog2(BAUD_DIV);
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [BW-1:0] BAUD_TC = BW'(BAUD_DIV - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(UART_DATA_BITS - 1);
    uart_tx_state_t state;
    logic [BW-1:0] baud_cnt;
    logic [IW-1:0] bit_idx;
    logic stop_idx;
    logic [UART_DATA_BITS-1:0] shift, fifo_dout;
    logic fifo_full, push, pop, baud_tc, stop_done;
    assign baud_tc   = baud_cnt == BAUD_TC;
    assign stop_done = baud_tc && stop_idx == 1'(STOP_BITS - 1);
    assign push      = tx_valid && !fifo_full;
    assign pop       = !fifo_empty && (state == IDLE || (state == STOP && stop_done));
    assign tx_ready  = !fifo_full;
    uart_byte_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .din(tx_data),
        .dout(fifo_dout),
        .count(fifo_count),
        .full(fifo_full),
        .empty(fifo_empty)
    );
    // A pop overrides whatever the state case decided, so STOP can chain straight into START.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shift    <= '0;
            uart_tx  <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            baud_cnt <= (state == IDLE || baud_tc) ? '0 : baud_cnt + BW'(1);
            case (state)
                START: if (baud_tc) begin
                    uart_tx <= shift[0];
                    shift   <= shift >> 1;
                    bit_idx <= '0;
                    state   <= DATA;
                end
                DATA: if (baud_tc) begin
                    if (bit_idx == LAST_BIT) begin
                        uart_tx  <= 1'b1;
                        stop_idx <= 1'b0;
                        state    <= STOP;
                    end else begin
                        uart_tx <= shift[0];
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + IW'(1);
                    end
                end
                STOP: if (stop_done) begin
                    state   <= IDLE;
                    tx_busy <= 1'b0;
                end else if (baud_tc) stop_idx <= 1'b1;
                default: ;
            endcase
            if (pop) begin
                shift   <= fifo_dout;
                uart_tx <= 1'b0;
                tx_busy <= 1'b1;
                state   <= START;
            end
        end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: two transmitters (1 and 2 stop bits) checked every cycle against a frame-timeline model.
module tb_uart_tx_buffered;
    localparam int BD = 4;
    int depth [2] = '{16, 4};
    int fl [2] = '{40, 44};
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    logic [7:0] dat [2];
    logic vld [2];
    logic utx [2], busy [2], rdy [2], emp [2];
    logic [4:0] cnt_a;
    logic [2:0] cnt_b;
    uart_tx_buffered #(.BAUD_DIV(BD), .FIFO_DEPTH(16), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .tx_data(dat[0]), .tx_valid(vld[0]), .tx_ready(rdy[0]),
        .uart_tx(utx[0]), .tx_busy(busy[0]), .fifo_count(cnt_a), .fifo_empty(emp[0])
    );
    uart_tx_buffered #(.BAUD_DIV(BD), .FIFO_DEPTH(4), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .tx_data(dat[1]), .tx_valid(vld[1]), .tx_ready(rdy[1]),
        .uart_tx(utx[1]), .tx_busy(busy[1]), .fifo_count(cnt_b), .fifo_empty(emp[1])
    );
    // model: buffered bytes, position in the current frame (-1 idle) and the byte on the line
    logic [7:0] mq [2][64];
    int mh [2] = '{0, 0};
    int mc [2] = '{0, 0};
    int t [2] = '{-1, -1};
    logic [7:0] cur [2];
    bit acc [2] = '{0, 0};
    logic [7:0] pbuf [2][64];
    int ph [2] = '{0, 0};
    int pc [2] = '{0, 0};
    int n_cmp = 0, n_bad = 0;
    logic s [200], bs [200];
    int cs [200];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic logic ex_tx(int k);
        int b;
        if (t[k] < 0) return 1'b1;
        b = t[k] / BD;
        if (b == 0) return 1'b0;
        if (b <= 8) return cur[k][b-1];
        return 1'b1;
    endfunction
    initial forever begin
        @(posedge clk or negedge rst);
        for (int k = 0; k < 2; k++)
            if (!rst) begin
                mh[k] = 0; mc[k] = 0; t[k] = -1; acc[k] = 0;
            end else begin
                bit psh;
                psh = vld[k] && mc[k] != depth[k];
                if (t[k] >= 0) begin
                    t[k]++;
                    if (t[k] == fl[k]) t[k] = -1;
                end
                if (t[k] < 0 && mc[k] > 0) begin
                    cur[k] = mq[k][mh[k]];
                    mh[k] = (mh[k] + 1) % 64;
                    mc[k]--;
                    t[k] = 0;
                end
                if (psh) begin
                    mq[k][(mh[k] + mc[k]) % 64] = dat[k];
                    mc[k]++;
                end
                acc[k] = psh;
            end
    end
    initial begin
        vld = '{1'b0, 1'b0};
        dat = '{8'h00, 8'h00};
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (acc[k] && pc[k] > 0) begin
                    ph[k] = (ph[k] + 1) % 64;
                    pc[k]--;
                end
                vld[k] = pc[k] > 0;
                dat[k] = pc[k] > 0 ? pbuf[k][ph[k]] : 8'h00;
            end
        end
    end
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("uart_tx[%0d]", k), 32'(utx[k]), 32'(ex_tx(k)));
            chk($sformatf("tx_busy[%0d]", k), 32'(busy[k]), 32'(t[k] >= 0));
            chk($sformatf("fifo_count[%0d]", k), k ? 32'(cnt_b) : 32'(cnt_a), mc[k]);
            chk($sformatf("fifo_empty[%0d]", k), 32'(emp[k]), 32'(mc[k] == 0));
            chk($sformatf("tx_ready[%0d]", k), 32'(rdy[k]), 32'(mc[k] != depth[k]));
        end
    end
    task automatic add(input int k, input logic [7:0] b);
        pbuf[k][(ph[k] + pc[k]) % 64] = b;
        pc[k]++;
    endtask
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic capture(input int k, input int n);
        @(posedge clk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s[i] = utx[k];
            bs[i] = busy[k];
            cs[i] = k ? 32'(cnt_b) : 32'(cnt_a);
        end
        cyc(1);
    endtask
    task automatic drain();
        int i;
        for (i = 0; i < 3000; i++) begin
            if (pc[0] == 0 && pc[1] == 0 && mc[0] == 0 && mc[1] == 0 && t[0] < 0 && t[1] < 0) break;
            cyc(1);
        end
        chk("drain_within_budget", 32'(i < 3000), 1);
    endtask
    initial begin
        logic [9:0] pat;
        int nb, nf, f0, f1, mx, w;
        pat = 10'b1010000010;
        cyc(1);
        chk("reset_uart_tx", 32'(utx[0]), 1);
        chk("reset_busy", 32'(busy[0]), 0);
        chk("reset_count", 32'(cnt_a), 0);
        chk("reset_ready", 32'(rdy[0]), 1);
        chk("reset_empty", 32'(emp[0]), 1);
        #2 rst = 1'b1;
        cyc(2);
        // single 0x41 frame
        add(0, 8'h41);
        capture(0, 45);
        chk("t1_idle_before_start", 32'(s[0]), 1);
        for (int j = 0; j < 10; j++) chk($sformatf("t1_bit%0d", j), 32'(s[1 + 4*j + 2]), 32'(pat[j]));
        nb = 0;
        for (int i = 0; i < 45; i++) nb += int'(bs[i]);
        chk("t1_busy_clocks", nb, 40);
        chk("t1_busy_last", 32'(bs[40]), 1);
        chk("t1_idle_after", 32'(bs[41]), 0);
        // three back-to-back frames
        add(0, 8'h55); add(0, 8'hAA); add(0, 8'h0F);
        capture(0, 130);
        nb = 0; mx = 0;
        for (int i = 0; i < 130; i++) begin
            nb += int'(bs[i]);
            if (cs[i] > mx) mx = cs[i];
        end
        chk("t2_busy_clocks", nb, 120);
        chk("t2_busy_end", 32'(bs[120]), 1);
        chk("t2_peak_count", mx, 2);
        chk("t2_count_after_f1", cs[41], 1);
        chk("t2_count_after_f2", cs[81], 0);
        chk("t2_gapless_start2", 32'(s[41]), 0);
        // fill the FIFO: 18 bytes offered, 17 accepted before ready drops
        for (int i = 0; i < 18; i++) add(0, 8'h10 + 8'(i));
        @(posedge clk);
        repeat (16) @(posedge clk);
        @(negedge clk);
        chk("t3_full_count", 32'(cnt_a), 16);
        chk("t3_ready_low", 32'(rdy[0]), 0);
        repeat (25) @(posedge clk);
        @(negedge clk);
        chk("t3_count_after_pop", 32'(cnt_a), 15);
        chk("t3_ready_after_pop", 32'(rdy[0]), 1);
        @(negedge clk);
        chk("t3_refilled", 32'(cnt_a), 16);
        cyc(1);
        drain();
        // reset mid data bit 3 of 0xC3
        add(0, 8'hC3);
        for (w = 0; w < 100 && t[0] != 17; w++) cyc(1);
        chk("t4_reached_bit3", 32'(w < 100), 1);
        chk("t4_bit3_level", 32'(utx[0]), 0);
        #2 rst = 1'b0;
        pc = '{0, 0};
        #1;
        chk("t4_abort_tx", 32'(utx[0]), 1);
        chk("t4_abort_busy", 32'(busy[0]), 0);
        chk("t4_abort_count", 32'(cnt_a), 0);
        cyc(2);
        #2 rst = 1'b1;
        capture(0, 60);
        nb = 0;
        for (int i = 0; i < 60; i++) nb += int'(!s[i]) + int'(bs[i]);
        chk("t4_line_quiet", nb, 0);
        // two stop bits
        add(1, 8'hFF); add(1, 8'hFF);
        capture(1, 100);
        nf = 0; f0 = -1; f1 = -1; nb = 0;
        for (int i = 1; i < 100; i++)
            if (s[i-1] && !s[i]) begin
                nf++;
                if (f0 < 0) f0 = i; else f1 = i;
            end
        for (int i = 0; i < 100; i++) nb += int'(bs[i]);
        chk("t5_frames", nf, 2);
        chk("t5_spacing", f1 - f0, 44);
        chk("t5_stop_last", 32'(s[44]), 1);
        chk("t5_busy_clocks", nb, 88);
        // push on the edge where a stop bit ends with one byte buffered
        add(0, 8'hA1); add(0, 8'hB2);
        for (w = 0; w < 200 && !(t[0] == 39 && cur[0] == 8'hA1); w++) cyc(1);
        chk("t6_reached_stop_end", 32'(w < 200), 1);
        add(0, 8'hC3);
        @(posedge clk);
        @(negedge clk);
        chk("t6_count_steady", 32'(cnt_a), 1);
        chk("t6_next_start", 32'(utx[0]), 0);
        cyc(1);
        drain();
        // random traffic on both transmitters
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 2; k++)
                repeat ($urandom_range(0, 12)) add(k, 8'($urandom));
            cyc($urandom_range(1, 200));
        end
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
